// File: rtl/fp16_pkg.sv
// Shared fp16 types and helpers for the multiplier result path.
package fp16_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t      FP16_QNAN    = 16'h7E00;
  localparam logic [4:0] FP16_EXP_MAX = 5'h1F;

  function automatic logic fp16_is_nan(input fp16_t x);
    return (x[14:10] == FP16_EXP_MAX) && (x[9:0] != 10'd0);
  endfunction

endpackage

// File: rtl/fp16_result_drain_if.sv
// Downstream valid/ready result handshake; master drives the head entry.
interface fp16_result_drain_if;
  import fp16_pkg::*;

  logic  out_valid;
  logic  out_ready;
  fp16_t out_data;
  logic  out_nan;

  modport master (output out_valid, output out_data, output out_nan, input out_ready);
  modport slave  (input out_valid, input out_data, input out_nan, output out_ready);

endinterface

// File: rtl/fp16_sync_fifo.sv
// Show-ahead synchronous FIFO; head is registered, so rd_data has no path from wr_data.
// A write while full is dropped unless a read frees a slot in the same cycle.
module fp16_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             rd_ok, wr_ok;

  assign rd_ok = rd_en && (count_q != '0);
  assign wr_ok = wr_en && ((count_q != FULL) || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  // Empty FIFO presents zero rather than stale storage.
  assign rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

endmodule

// File: rtl/fp16_result_drain.sv
// Credit-managed drain for the un-stallable fp16 multiplier stream; result visible one cycle after arrival.
// Optional FP16_CANON_NAN_EN canonicalises NaNs on write and flags them per entry.
module fp16_result_drain
  import fp16_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  output logic                       issue_ok,
  input  logic                       m_axis_result_tvalid,
  input  logic [31:0]                m_axis_result_tdata,
  fp16_result_drain_if.master        out_if,
  output logic [CW-1:0]              in_flight,
  output logic                       overflow
);
`ifdef FP16_CANON_NAN_EN
  localparam int FW = 17;
`else
  localparam int FW = 16;
`endif
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] in_flight_q, in_flight_d, fifo_count;
  logic          overflow_q, overflow_d;
  logic          result_ok, pop, fifo_full;
  logic [FW-1:0] wr_word, rd_word;
  logic          unused_tdata_hi;

  assign unused_tdata_hi = ^m_axis_result_tdata[31:16];

  // Sum can exceed DEPTH only after a protocol violation, so compare one bit wider.
  assign issue_ok  = ({1'b0, in_flight_q} + {1'b0, fifo_count}) < {1'b0, DEPTH_C};
  assign result_ok = m_axis_result_tvalid && (in_flight_q != '0);
  assign pop       = out_if.out_valid && out_if.out_ready;
  assign fifo_full = (fifo_count == DEPTH_C);

  always_comb begin
    in_flight_d = in_flight_q;
    if (issue_valid && !result_ok) begin
      if (in_flight_q != DEPTH_C) in_flight_d = in_flight_q + CW'(1);
    end else if (!issue_valid && result_ok) begin
      in_flight_d = in_flight_q - CW'(1);
    end
    overflow_d = overflow_q
               | (issue_valid && !issue_ok)
               | (m_axis_result_tvalid && (in_flight_q == '0))
               | (result_ok && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef FP16_CANON_NAN_EN
  logic wr_nan;
  assign wr_nan  = fp16_is_nan(m_axis_result_tdata[15:0]);
  assign wr_word = {wr_nan, wr_nan ? {m_axis_result_tdata[15], FP16_QNAN[14:0]}
                                   : m_axis_result_tdata[15:0]};
  assign out_if.out_data = rd_word[15:0];
  assign out_if.out_nan  = rd_word[16];
`else
  assign wr_word         = m_axis_result_tdata[15:0];
  assign out_if.out_data = rd_word;
  assign out_if.out_nan  = 1'b0;
`endif

  fp16_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (result_ok),
    .wr_data (wr_word),
    .rd_en   (pop),
    .rd_data (rd_word),
    .count   (fifo_count)
  );

  assign out_if.out_valid = (fifo_count != '0);
  assign in_flight        = in_flight_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_fp16_result_drain.sv
// Directed and random stimulus against a queue-based model of the result drain.
module tb_fp16_result_drain;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_ok;
  logic          tvalid = 1'b0;
  logic [31:0]   tdata = '0;
  logic [CW-1:0] in_flight;
  logic          overflow;

  fp16_result_drain_if out_if ();

  fp16_result_drain #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .issue_valid          (issue_valid),
    .issue_ok             (issue_ok),
    .m_axis_result_tvalid (tvalid),
    .m_axis_result_tdata  (tdata),
    .out_if               (out_if),
    .in_flight            (in_flight),
    .overflow             (overflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mq[$];
  int          m_inflight = 0;
  bit          m_ovf = 1'b0;

  function automatic logic [15:0] canon(input logic [15:0] d);
`ifdef FP16_CANON_NAN_EN
    if (((d >> 10) & 16'h1F) == 16'h1F && (d & 16'h3FF) != 0) return (d & 16'h8000) | 16'h7E00;
`endif
    return d;
  endfunction

  function automatic bit is_nan(input logic [15:0] d);
`ifdef FP16_CANON_NAN_EN
    return ((d >> 10) & 16'h1F) == 16'h1F && (d & 16'h3FF) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_ok();
    return (DEPTH - m_inflight - mq.size()) > 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] hd;
    hd = (mq.size() != 0) ? mq[0] : 16'h0000;
    check({tag, ".out_valid"}, 32'(out_if.out_valid), 32'(mq.size() != 0));
    check({tag, ".out_data"},  32'(out_if.out_data),  32'(hd));
    check({tag, ".out_nan"},   32'(out_if.out_nan),   32'((mq.size() != 0) && is_nan(hd)));
    check({tag, ".in_flight"}, 32'(in_flight),        32'(m_inflight));
    check({tag, ".overflow"},  32'(overflow),         32'(m_ovf));
    check({tag, ".issue_ok"},  32'(issue_ok),         32'(model_ok()));
  endtask

  task automatic cyc(input bit iv, input bit tv, input logic [31:0] td, input bit rdy, input string tag);
    bit pop, ok, res, was_full;
    issue_valid = iv; tvalid = tv; tdata = td; out_if.out_ready = rdy;
    @(posedge clk);
    pop      = (mq.size() != 0) && rdy;
    ok       = model_ok();
    res      = tv && (m_inflight > 0);
    was_full = (mq.size() == DEPTH);
    if (iv && !ok) m_ovf = 1'b1;
    if (tv && m_inflight == 0) m_ovf = 1'b1;
    if (pop) void'(mq.pop_front());
    if (res) begin
      if (was_full && !pop) m_ovf = 1'b1;
      else mq.push_back(canon(td[15:0]));
    end
    m_inflight = m_inflight + int'(iv) - int'(res);
    if (m_inflight > DEPTH) m_inflight = DEPTH;
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; issue_valid = 1'b0; tvalid = 1'b0; tdata = '0; out_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); m_inflight = 0; m_ovf = 1'b0;
    check_all("reset");
    check("reset.data_zero", 32'(out_if.out_data), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    bit          iv, tv, rdy;
    logic [31:0] td;
    out_if.out_ready = 1'b0;

    do_reset();

    // Single operation
    cyc(1, 0, 32'h0, 1, "single.issue");
    cyc(0, 0, 32'h0, 1, "single.wait1");
    cyc(0, 0, 32'h0, 1, "single.wait2");
    cyc(0, 1, 32'hABCD_3C00, 1, "single.result");
    check("single.head", 32'(out_if.out_data), 32'h3C00);
    cyc(0, 0, 32'h0, 1, "single.popped");

    // Credit backpressure and ordered drain
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 32'h0, 0, "bp.issue");
    check("bp.issue_ok_low", 32'(issue_ok), 32'h0);
    for (int i = 1; i <= DEPTH; i++) cyc(0, 1, 32'(i), 0, "bp.result");
    for (int i = 1; i <= DEPTH; i++) begin
      check("bp.drain_order", 32'(out_if.out_data), 32'(i));
      cyc(0, 0, 32'h0, 1, "bp.drain");
    end

    // Full FIFO with a protocol violation: extra issue, then write to a full FIFO
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 32'h0, 0, "full.issue");
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 32'(16'h100 + i), 0, "full.result");
    cyc(1, 0, 32'h0, 0, "full.bad_issue");
    cyc(0, 1, 32'h0000_0BAD, 0, "full.drop");
    check("full.ovf", 32'(overflow), 32'h1);

    // Simultaneous issue, result and pop with count=3, in_flight=2
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 32'h0, 0, "sim.issue");
    cyc(0, 1, 32'h11, 0, "sim.r1");
    cyc(0, 1, 32'h22, 0, "sim.r2");
    cyc(0, 1, 32'h33, 0, "sim.r3");
    cyc(1, 1, 32'h44, 1, "sim.all");
    check("sim.head", 32'(out_if.out_data), 32'h22);
    check("sim.inflight", 32'(in_flight), 32'd2);

    // Unexpected result
    do_reset();
    cyc(0, 1, 32'h0000_4000, 0, "unexp.result");
    check("unexp.ovf", 32'(overflow), 32'h1);
    cyc(1, 0, 32'h0, 0, "unexp.traffic1");
    cyc(0, 1, 32'h0000_1234, 1, "unexp.traffic2");
    cyc(0, 0, 32'h0, 1, "unexp.traffic3");
    do_reset();

    // NaN handling
    cyc(1, 0, 32'h0, 0, "nan.issue");
    cyc(0, 1, 32'h0000_FC01, 0, "nan.result");
`ifdef FP16_CANON_NAN_EN
    check("nan.data", 32'(out_if.out_data), 32'hFE00);
    check("nan.flag", 32'(out_if.out_nan), 32'h1);
`else
    check("nan.data", 32'(out_if.out_data), 32'hFC01);
    check("nan.flag", 32'(out_if.out_nan), 32'h0);
`endif
    cyc(0, 0, 32'h0, 1, "nan.pop");

    // Randomised legal traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      iv  = model_ok() && ($urandom_range(0, 2) != 0);
      tv  = (m_inflight > 0) && ($urandom_range(0, 1) != 0);
      td  = $urandom;
      if ($urandom_range(0, 7) == 0) td[14:10] = 5'h1F;
      rdy = ($urandom_range(0, 3) != 0);
      cyc(iv, tv, td, rdy, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
